// File: rtl/stable_matching_pkg.sv
// Shared types, default sizes and index helpers for the stable-matching blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stable_matching_pkg;

    // Default geometry: proposers, receivers and preference-list lengths.
    localparam int S_DEF  = 3;
    localparam int R_DEF  = 3;
    localparam int KS_DEF = 2;
    localparam int KR_DEF = 2;

    // Ceiling log2 with a floor of one bit, so single-entry fields still get a wire.
    function automatic int log2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // LSB of proposer s, rank k inside the packed s_pref bus.
    function automatic int s_pref_lsb(input int s, input int k, input int ks, input int logr);
        return logr * (s * ks + k);
    endfunction

    // LSB of receiver r, rank k inside the packed r_pref bus.
    function automatic int r_pref_lsb(input int r, input int k, input int kr, input int logs);
        return logs * (r * kr + k);
    endfunction

    // Controller FSM: waiting for start, or issuing one proposal per clock.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sm_state_e;

endpackage

// File: rtl/sm_rank_lookup.sv
// Finds a proposer's rank in one receiver's preference list; absent means not found.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module sm_rank_lookup
    import stable_matching_pkg::*;
#(
    parameter int  Kr    = KR_DEF,
    parameter int  S     = S_DEF,
    localparam int logS  = log2(S),
    localparam int logKr = log2(Kr)
) (
    input  logic [Kr*logS-1:0] pref_list,
    input  logic [logS-1:0]    s_idx,
    output logic               found,
    output logic [logKr-1:0]   rank
);

    // Scan from the least preferred end so the most preferred duplicate wins.
    always_comb begin
        found = 1'b0;
        rank  = '0;
        for (int k = Kr - 1; k >= 0; k--) begin
            if (pref_list[logS*k +: logS] == s_idx) begin
                found = 1'b1;
                rank  = logKr'(k);
            end
        end
    end

endmodule

// File: rtl/stable_matching_seq_ctrl.sv
// Sequential Gale-Shapley scheduler: one proposal per clock from captured preference lists.
// Latency: done pulses P+1 cycles after the start-sampling edge for P proposals.
// Backpressure: start is ignored while busy; results hold in IDLE until the next accepted start.
module stable_matching_seq_ctrl
    import stable_matching_pkg::*;
#(
    parameter int  Kr    = KR_DEF,
    parameter int  Ks    = KS_DEF,
    parameter int  S     = S_DEF,
    parameter int  R     = R_DEF,
    localparam int logS  = log2(S),
    localparam int logR  = log2(R),
    localparam int logKs = log2(Ks),
    localparam int CNTW  = log2(S*Ks+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [S*Ks*logR-1:0]  s_pref,
    input  logic [R*Kr*logS-1:0]  r_pref,
    output logic                  busy,
    output logic                  done,
    output logic [R*logS-1:0]     match_list,
    output logic [R-1:0]          r_matched,
    output logic [S-1:0]          s_matched,
    output logic [CNTW-1:0]       proposal_cnt
);

    localparam int logKr = log2(Kr);
    // Pointer must be able to reach Ks itself ("list exhausted").
    localparam int PTRW  = logKs + 1;

    sm_state_e           state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [logS-1:0]     match_q [R];
    logic [logS-1:0]     match_d [R];
    logic [R-1:0]        rm_q, rm_d;
    logic [S-1:0]        sm_q, sm_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [PTRW-1:0]     ptr_q [S];
    logic [PTRW-1:0]     ptr_d [S];
    logic [logR-1:0]     sp_q [S][Ks];
    logic [logR-1:0]     sp_d [S][Ks];
    logic [Kr*logS-1:0]  rp_q [R];
    logic [Kr*logS-1:0]  rp_d [R];

    logic [logR-1:0]     sp_in [S][Ks];
    logic [Kr*logS-1:0]  rp_in [R];

    logic                sel_vld;
    logic [logS-1:0]     sel_s;
    logic [logR-1:0]     tgt;
    logic                tgt_ok;
    logic [logR-1:0]     tgt_idx;
    logic [logS-1:0]     holder;
    logic                p_found, h_found;
    logic [logKr-1:0]    p_rank, h_rank;
    logic                accept;

    // Unpack the input preference buses into per-member lists for capture.
    always_comb begin
        for (int s = 0; s < S; s++) begin
            for (int k = 0; k < Ks; k++) begin
                sp_in[s][k] = s_pref[s_pref_lsb(s, k, Ks, logR) +: logR];
            end
        end
        for (int r = 0; r < R; r++) begin
            rp_in[r] = r_pref[r_pref_lsb(r, 0, Kr, logS) +: Kr*logS];
        end
    end

    // Priority encoder: lowest-index free proposer that still has list entries left.
    always_comb begin
        sel_vld = 1'b0;
        sel_s   = '0;
        for (int s = S - 1; s >= 0; s--) begin
            if (!sm_q[s] && (int'(ptr_q[s]) < Ks)) begin
                sel_vld = 1'b1;
                sel_s   = logS'(s);
            end
        end
    end

    // Resolve the proposal target; out-of-range receivers are steered to entry 0 and gated off.
    always_comb begin
        tgt     = sel_vld ? sp_q[sel_s][ptr_q[sel_s][logKs-1:0]] : '0;
        tgt_ok  = sel_vld && (int'(tgt) < R);
        tgt_idx = tgt_ok ? tgt : '0;
        holder  = match_q[tgt_idx];
    end

    sm_rank_lookup #(
        .Kr (Kr),
        .S  (S)
    ) u_rank_prop (
        .pref_list (rp_q[tgt_idx]),
        .s_idx     (sel_s),
        .found     (p_found),
        .rank      (p_rank)
    );

    sm_rank_lookup #(
        .Kr (Kr),
        .S  (S)
    ) u_rank_hold (
        .pref_list (rp_q[tgt_idx]),
        .s_idx     (holder),
        .found     (h_found),
        .rank      (h_rank)
    );

    // Receiver takes the proposer if free, or if the proposer outranks the current holder.
    // A holder is always ranked (it was accepted), so !h_found only guards an unreachable case.
    always_comb begin
        accept = tgt_ok && p_found &&
                 (!rm_q[tgt_idx] || !h_found || (p_rank < h_rank));
    end

    // Next-state: capture on start in IDLE, one proposal per cycle in RUN, done when nobody can propose.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        match_d = match_q;
        rm_d    = rm_q;
        sm_d    = sm_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sp_d    = sp_q;
        rp_d    = rp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sp_d  = sp_in;
                    rp_d  = rp_in;
                    rm_d  = '0;
                    sm_d  = '0;
                    cnt_d = '0;
                    for (int r = 0; r < R; r++) begin
                        match_d[r] = '0;
                    end
                    for (int s = 0; s < S; s++) begin
                        ptr_d[s] = '0;
                    end
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!sel_vld) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ptr_d[sel_s] = ptr_q[sel_s] + PTRW'(1);
                    cnt_d        = cnt_q + CNTW'(1);
                    if (accept) begin
                        if (rm_q[tgt_idx]) begin
                            sm_d[holder] = 1'b0;
                        end
                        match_d[tgt_idx] = sel_s;
                        rm_d[tgt_idx]    = 1'b1;
                        sm_d[sel_s]      = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rm_q    <= '0;
            sm_q    <= '0;
            cnt_q   <= '0;
            for (int r = 0; r < R; r++) begin
                match_q[r] <= '0;
                rp_q[r]    <= '0;
            end
            for (int s = 0; s < S; s++) begin
                ptr_q[s] <= '0;
                for (int k = 0; k < Ks; k++) begin
                    sp_q[s][k] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
            rm_q    <= rm_d;
            sm_q    <= sm_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sp_q    <= sp_d;
            rp_q    <= rp_d;
        end
    end

    // Pack the per-receiver match registers onto the output bus.
    always_comb begin
        match_list = '0;
        for (int r = 0; r < R; r++) begin
            match_list[logS*r +: logS] = match_q[r];
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign r_matched    = rm_q;
    assign s_matched    = sm_q;
    assign proposal_cnt = cnt_q;

endmodule

// File: tb/tb_stable_matching_seq_ctrl.sv
// Scoreboard bench: stimulus pushes model results, a monitor checks them on each done pulse.
// Latency: n/a.
// Backpressure: n/a.
module tb_stable_matching_seq_ctrl;

    localparam int S = 3;
    localparam int R = 3;
    localparam int KS = 2;
    localparam int KR = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] s_pref;
    logic [11:0] r_pref;
    logic        busy;
    logic        done;
    logic [5:0]  match_list;
    logic [2:0]  r_matched;
    logic [2:0]  s_matched;
    logic [2:0]  proposal_cnt;

    typedef struct {
        logic [5:0] match;
        logic [2:0] rm;
        logic [2:0] sm;
        int         cnt;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    stable_matching_seq_ctrl #(.Kr(KR), .Ks(KS), .S(S), .R(R)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_pref       (s_pref),
        .r_pref       (r_pref),
        .busy         (busy),
        .done         (done),
        .match_list   (match_list),
        .r_matched    (r_matched),
        .s_matched    (s_matched),
        .proposal_cnt (proposal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Pack six 2-bit entries, entry i at bits [2i+1:2i] (member i/2, rank i%2).
    function automatic logic [11:0] pk(input int a0, input int a1, input int b0,
                                       input int b1, input int c0, input int c1);
        logic [11:0] v;
        v = {c1[1:0], c0[1:0], b1[1:0], b0[1:0], a1[1:0], a0[1:0]};
        return v;
    endfunction

    function automatic int rank_of(input logic [11:0] rpb, input int r, input int s);
        for (int k = 0; k < KR; k++) begin
            if (int'(rpb[2*(r*KR+k) +: 2]) == s) return k;
        end
        return -1;
    endfunction

    // Reference Gale-Shapley: repeatedly let the lowest free proposer with entries left propose.
    task automatic model(input logic [11:0] spb, input logic [11:0] rpb, output exp_t e);
        int  nxt[S];
        int  hold[R];
        bit  rfull[R];
        bit  sbusy[S];
        int  cnt;
        int  s;
        int  r;
        int  rk;
        cnt = 0;
        for (int i = 0; i < S; i++) begin nxt[i] = 0; sbusy[i] = 0; end
        for (int i = 0; i < R; i++) begin hold[i] = 0; rfull[i] = 0; end
        for (int guard = 0; guard < 64; guard++) begin
            s = -1;
            for (int i = S - 1; i >= 0; i--) if (!sbusy[i] && nxt[i] < KS) s = i;
            if (s < 0) break;
            r = int'(spb[2*(s*KS+nxt[s]) +: 2]);
            nxt[s] = nxt[s] + 1;
            cnt = cnt + 1;
            if (r < R) begin
                rk = rank_of(rpb, r, s);
                if (rk >= 0) begin
                    if (!rfull[r]) begin
                        rfull[r] = 1; hold[r] = s; sbusy[s] = 1;
                    end else if (rk < rank_of(rpb, r, hold[r])) begin
                        sbusy[hold[r]] = 0; hold[r] = s; sbusy[s] = 1;
                    end
                end
            end
        end
        e.match = '0;
        e.rm    = '0;
        e.sm    = '0;
        for (int i = 0; i < R; i++) begin
            if (rfull[i]) e.match[2*i +: 2] = 2'(hold[i]);
            e.rm[i] = rfull[i];
        end
        for (int i = 0; i < S; i++) e.sm[i] = sbusy[i];
        e.cnt      = cnt;
        e.done_cyc = 0;
    endtask

    // Called at a negedge while the DUT is idle: present prefs, pulse start, then scramble inputs.
    task automatic issue(input logic [11:0] spb, input logic [11:0] rpb);
        exp_t e;
        s_pref = spb;
        r_pref = rpb;
        start  = 1'b1;
        model(spb, rpb, e);
        e.done_cyc = cyc + e.cnt + 2;
        exp_q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        s_pref = 12'($urandom);
        r_pref = 12'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("run_timeout", n, 0);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_match"}, int'(match_list), 0);
        chk({nm, "_rm"}, int'(r_matched), 0);
        chk({nm, "_sm"}, int'(s_matched), 0);
        chk({nm, "_cnt"}, int'(proposal_cnt), 0);
    endtask

    // Monitor: every done pulse must correspond to the oldest outstanding run.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && done === 1'b1) begin
                chk("done_expected", exp_q.size() > 0 ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("no_x", int'($isunknown({match_list, r_matched, s_matched, proposal_cnt, busy})), 0);
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("busy_low_at_done", int'(busy), 0);
                    chk("proposal_cnt", int'(proposal_cnt), e.cnt);
                    chk("r_matched", int'(r_matched), int'(e.rm));
                    chk("s_matched", int'(s_matched), int'(e.sm));
                    for (int r = 0; r < R; r++) begin
                        if (e.rm[r]) chk("match_list", int'(match_list[2*r +: 2]), int'(e.match[2*r +: 2]));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    logic [11:0] base_s, base_r;
    int          n;

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        s_pref = '0;
        r_pref = '0;
        base_s = pk(0, 1, 0, 2, 1, 0);
        base_r = pk(1, 0, 0, 2, 1, 2);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Base case, plus directed constants for the known answer.
        issue(base_s, base_r);
        wait_idle();
        chk("base_cnt", int'(proposal_cnt), 5);
        chk("base_match", int'(match_list[3:0]), 4'b0001);
        chk("base_rm", int'(r_matched), 3'b011);
        chk("base_sm", int'(s_matched), 3'b011);

        // Results hold in IDLE.
        repeat (3) @(negedge clk);
        chk("hold_cnt", int'(proposal_cnt), 5);

        // Perfect match.
        issue(pk(0, 1, 1, 2, 2, 0), pk(0, 2, 1, 0, 2, 1));
        wait_idle();
        chk("perfect_match", int'(match_list), 6'b10_01_00);

        // All rejected except s0.
        issue(pk(0, 1, 1, 2, 2, 1), pk(0, 0, 0, 0, 0, 0));
        wait_idle();

        // Out-of-range targets.
        issue(pk(3, 0, 0, 3, 3, 3), base_r);
        wait_idle();

        // start mid-run is ignored; the original captured prefs decide the result.
        issue(base_s, base_r);
        start  = 1'b1;
        s_pref = pk(0, 1, 1, 2, 2, 0);
        r_pref = pk(0, 2, 1, 0, 2, 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_during_ignored_start", int'(busy), 1);
        wait_idle();

        // start on the done cycle launches a second run.
        @(negedge clk);
        issue(pk(0, 1, 1, 2, 2, 0), base_r);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("first_done_seen", int'(done), 1);
        issue(base_s, base_r);
        wait_idle();

        // Reset mid-run: outputs clear at once and no done follows.
        @(negedge clk);
        issue(base_s, base_r);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("midrun_reset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Randomized runs, including out-of-range targets and absent proposers.
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            issue(12'($urandom), 12'($urandom));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stable_matching_seq_ctrl.md
Name: stable_matching_seq_ctrl

Overview:
- Sequential Gale-Shapley scheduler for the stable-matching datapath.
- List A members (S proposers) propose to list B members (R receivers), one proposal per clock, until no free proposer has preferences left.
- Serves as the clocked, handshaked counterpart to stable_matching_comb.
- Captures both preference lists on start, runs the proposal schedule, then holds the final match list until the next start.

Parameters:
- Kr, 2, preference-list length of each list-B receiver.
- Ks, 2, preference-list length of each list-A proposer.
- S, 3, number of list-A members (proposers).
- R, 3, number of list-B members (receivers).
- Derived localparams: logS=log2(S), logR=log2(R), logKs=log2(Ks), CNTW=log2(S*Ks+1).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  load preferences and begin a run; ignored while busy.
- s_pref  in  S*Ks*logR  proposer s, rank k at [logR*(s*Ks+k) +: logR]; rank 0 is most preferred.
- r_pref  in  R*Kr*logS  receiver r, rank k at [logS*(r*Kr+k) +: logS]; rank 0 is most preferred.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- match_list  out  R*logS  proposer matched to receiver r, at [logS*r +: logS]; valid only where r_matched[r]=1.
- r_matched  out  R  receiver r currently holds a proposer.
- s_matched  out  S  proposer s currently engaged.
- proposal_cnt  out  CNTW  number of proposals issued in the current or last run.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; busy, done, match_list, r_matched, s_matched, proposal_cnt, all next-pointers and captured preferences cleared to 0.
- FSM states: IDLE, RUN.
- IDLE + start:
  - Capture s_pref and r_pref into registers; later input changes have no effect on the run.
  - Clear matches, pointers and proposal_cnt; set busy=1; go to RUN.
- RUN, each cycle:
  - A priority encoder selects the lowest-index s with s_matched[s]=0 and ptr[s]<Ks.
  - If no such s: busy=0, done=1 for exactly one cycle, go to IDLE.
  - Otherwise: target r = pref_s[s][ptr[s]]; ptr[s]++; proposal_cnt++.
- Rank lookup: rank of s in receiver r's list is the first k where pref_r[r][k]==s. If s is absent, s is rejected.
- Accept rules:
  - r free and s ranked: match_list[r]=s, r_matched[r]=1, s_matched[s]=1.
  - r holds c and rank(s) < rank(c): replace c with s, s_matched[c]=0, s_matched[s]=1, all in the same cycle.
  - Otherwise reject; s stays free.
- Out-of-range target (r>=R): counted as a proposal and rejected. Duplicate entries in a proposer's list are treated as independent proposals.
- Latency: with P proposals, done is high on the cycle P+1 after the start-sampling edge. P <= S*Ks, so proposal_cnt never wraps.
- start while busy: ignored. start on the same cycle done is high: FSM is already in IDLE, so the new run is accepted.
- Results (match_list, r_matched, s_matched, proposal_cnt) hold stable in IDLE until the next accepted start.
- Reset mid-run: abort immediately to the reset state; no done pulse.

Decomposition:
- Shared package stable_matching_pkg holds:
  - the log2 function;
  - default S, R, Ks, Kr;
  - pack/unpack index helpers for the pref buses;
  - FSM state enum.
- One sub-module, sm_rank_lookup. Combinational.
  - Inputs: one receiver's Kr-entry list and a proposer index.
  - Outputs: found flag and logKr rank.
  - Instantiated twice in the controller: once for the proposer, once for the current holder.

Test Plan (S=R=3, Ks=Kr=2):
- Base case:
  - Stimulus: s0(r0,r1), s1(r0,r2), s2(r1,r0); r0(s1,s0), r1(s0,s2), r2(s1,s2); start.
  - Required response: proposal_cnt=5; match r0=s1, r1=s0; r_matched=3'b011; s_matched=3'b011; done exactly 6 cycles after the start edge.
- Perfect match:
  - Stimulus: s_i(r_i, r_(i+1)%3); r_i(s_i, s_(i+2)%3).
  - Required response: 3 proposals; match_list r0=s0, r1=s1, r2=s2; all matched bits = 1.
- All rejected:
  - Stimulus: every r_pref entry = s0, proposers s1 and s2 target only r1 and r2.
  - Required response: s1 and s2 exhaust their lists; final r_matched shows only the receiver(s) s0 targeted; proposal_cnt=5 or 6 depending on s0's list, checked against the reference model.
- Out-of-range target:
  - Stimulus: an s_pref entry = 3.
  - Required response: rejected, still counted; no X propagated on any output.
- Control corner cases:
  - start pulsed mid-run → ignored; captured prefs unchanged.
  - start on the done cycle → a second run starts; its results equal those of a fresh run.
  - rst asserted mid-run → all outputs 0 in the same cycle; no done pulse.
